// File: rtl/crossbar_nxm.sv
// N-master x M-slave crossbar with one round-robin arbiter FSM per slave.
// Optional slave-ack watchdog is enabled by defining CROSSBAR_TIMEOUT_EN.
module crossbar_nxm #(
  parameter int N_MASTERS = 2,
  parameter int N_SLAVES  = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [N_MASTERS-1:0]               master_req,
  input  logic [N_MASTERS-1:0]               master_cmd,
  input  logic [N_MASTERS*ADDR_W-1:0]        master_addr,
  input  logic [N_MASTERS*DATA_W-1:0]        master_wdata,
  output logic [N_MASTERS-1:0]               master_ack,
  output logic [N_MASTERS*DATA_W-1:0]        master_rdata,
  output logic [N_MASTERS-1:0]               master_err,
  output logic [N_SLAVES-1:0]                slave_req,
  output logic [N_SLAVES-1:0]                slave_cmd,
  output logic [N_SLAVES*(ADDR_W-$clog2(N_SLAVES))-1:0] slave_addr,
  output logic [N_SLAVES*DATA_W-1:0]         slave_wdata,
  input  logic [N_SLAVES-1:0]                slave_ack,
  input  logic [N_SLAVES*DATA_W-1:0]         slave_rdata
);

  localparam int SEL_W = $clog2(N_SLAVES);
  localparam int SA_W  = ADDR_W - SEL_W;
  localparam int MW    = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  if (N_MASTERS < 2 || N_MASTERS > 8 || N_SLAVES < 2 || N_SLAVES > 8 ||
      (N_SLAVES & (N_SLAVES - 1)) != 0 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_check
    $error("crossbar_nxm: parameter out of range");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state     [N_SLAVES];
  state_t               state_nxt [N_SLAVES];
  logic [MW-1:0]        gnt       [N_SLAVES];
  logic [MW-1:0]        gnt_nxt   [N_SLAVES];
  logic [MW-1:0]        rr_ptr    [N_SLAVES];
  logic [MW-1:0]        rr_nxt    [N_SLAVES];
  logic [N_MASTERS-1:0] req_vec   [N_SLAVES];
  logic [N_SLAVES-1:0]  done_ok;
  logic [N_SLAVES-1:0]  done_to;
`ifdef CROSSBAR_TIMEOUT_EN
  logic [7:0]           cnt       [N_SLAVES];
  logic [7:0]           cnt_nxt   [N_SLAVES];
`endif

  always_comb begin
    for (int unsigned s = 0; s < N_SLAVES; s++) begin
      for (int unsigned m = 0; m < N_MASTERS; m++) begin
        req_vec[s][m] = master_req[m] &&
          (master_addr[m*ADDR_W + ADDR_W - SEL_W +: SEL_W] == SEL_W'(s));
      end
    end
  end

  always_comb begin
    for (int unsigned s = 0; s < N_SLAVES; s++) begin
      state_nxt[s] = state[s];
      gnt_nxt[s]   = gnt[s];
      rr_nxt[s]    = rr_ptr[s];
      done_ok[s]   = 1'b0;
      done_to[s]   = 1'b0;
`ifdef CROSSBAR_TIMEOUT_EN
      cnt_nxt[s]   = cnt[s];
`endif
      case (state[s])
        IDLE: begin
`ifdef CROSSBAR_TIMEOUT_EN
          cnt_nxt[s] = '0;
`endif
          // Descending scan: the last hit is the requester closest to rr_ptr.
          for (int unsigned k = N_MASTERS; k > 0; k--) begin
            if (req_vec[s][(32'(rr_ptr[s]) + k - 1) % 32'(N_MASTERS)])
              gnt_nxt[s] = MW'((32'(rr_ptr[s]) + k - 1) % 32'(N_MASTERS));
          end
          if (|req_vec[s]) state_nxt[s] = GRANT;
        end
        GRANT: begin
          if (slave_ack[s]) begin
            done_ok[s] = 1'b1;
          end
`ifdef CROSSBAR_TIMEOUT_EN
          else if (cnt[s] == 8'(TIMEOUT)) begin
            done_to[s] = 1'b1;
          end else begin
            cnt_nxt[s] = cnt[s] + 8'd1;
          end
`endif
          if (done_ok[s] || done_to[s]) begin
            state_nxt[s] = IDLE;
            rr_nxt[s]    = (gnt[s] == MW'(N_MASTERS - 1)) ? '0 : gnt[s] + MW'(1);
          end
        end
        default: state_nxt[s] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned s = 0; s < N_SLAVES; s++) begin
      if (reset) begin
        state[s]  <= IDLE;
        gnt[s]    <= '0;
        rr_ptr[s] <= '0;
`ifdef CROSSBAR_TIMEOUT_EN
        cnt[s]    <= '0;
`endif
      end else begin
        state[s]  <= state_nxt[s];
        gnt[s]    <= gnt_nxt[s];
        rr_ptr[s] <= rr_nxt[s];
`ifdef CROSSBAR_TIMEOUT_EN
        cnt[s]    <= cnt_nxt[s];
`endif
      end
    end
  end

  // The watchdog cycle drops the slave-side request while completing the master.
  always_comb begin
    slave_req    = '0;
    slave_cmd    = '0;
    slave_addr   = '0;
    slave_wdata  = '0;
    master_ack   = '0;
    master_err   = '0;
    master_rdata = '0;
    for (int unsigned s = 0; s < N_SLAVES; s++) begin
      if (state[s] == GRANT && !done_to[s]) begin
        slave_req[s]                   = 1'b1;
        slave_cmd[s]                   = master_cmd[gnt[s]];
        slave_addr[s*SA_W +: SA_W]     = master_addr[32'(gnt[s])*ADDR_W +: SA_W];
        slave_wdata[s*DATA_W +: DATA_W] = master_wdata[32'(gnt[s])*DATA_W +: DATA_W];
      end
      for (int unsigned m = 0; m < N_MASTERS; m++) begin
        if (state[s] == GRANT && gnt[s] == MW'(m)) begin
          master_ack[m] = master_ack[m] | done_ok[s] | done_to[s];
          master_err[m] = master_err[m] | done_to[s];
          if (done_ok[s])
            master_rdata[m*DATA_W +: DATA_W] = slave_rdata[s*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_crossbar_nxm.sv
// Directed self-checking bench for crossbar_nxm (2x2 and 4x4 instances).
module tb_crossbar_nxm;
  localparam int NM = 2, NS = 2, AW = 32, DW = 32, SAW = 31;
  localparam int BM = 4, BS = 4, BSAW = 30;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [NM-1:0]    a_mreq, a_mcmd, a_mack, a_merr;
  logic [NM*AW-1:0] a_maddr;
  logic [NM*DW-1:0] a_mwdata, a_mrdata;
  logic [NS-1:0]    a_sreq, a_scmd, a_sack;
  logic [NS*SAW-1:0] a_saddr;
  logic [NS*DW-1:0] a_swdata, a_srdata;

  logic [BM-1:0]    b_mreq, b_mcmd, b_mack, b_merr;
  logic [BM*AW-1:0] b_maddr;
  logic [BM*DW-1:0] b_mwdata, b_mrdata;
  logic [BS-1:0]    b_sreq, b_scmd, b_sack;
  logic [BS*BSAW-1:0] b_saddr;
  logic [BS*DW-1:0] b_swdata, b_srdata;

  int checks = 0;
  int errors = 0;

  crossbar_nxm #(.N_MASTERS(NM), .N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut_a (
    .clock(clock), .reset(reset),
    .master_req(a_mreq), .master_cmd(a_mcmd), .master_addr(a_maddr), .master_wdata(a_mwdata),
    .master_ack(a_mack), .master_rdata(a_mrdata), .master_err(a_merr),
    .slave_req(a_sreq), .slave_cmd(a_scmd), .slave_addr(a_saddr), .slave_wdata(a_swdata),
    .slave_ack(a_sack), .slave_rdata(a_srdata));

  crossbar_nxm #(.N_MASTERS(BM), .N_SLAVES(BS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut_b (
    .clock(clock), .reset(reset),
    .master_req(b_mreq), .master_cmd(b_mcmd), .master_addr(b_maddr), .master_wdata(b_mwdata),
    .master_ack(b_mack), .master_rdata(b_mrdata), .master_err(b_merr),
    .slave_req(b_sreq), .slave_cmd(b_scmd), .slave_addr(b_saddr), .slave_wdata(b_swdata),
    .slave_ack(b_sack), .slave_rdata(b_srdata));

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    a_mreq = '0; a_mcmd = '0; a_maddr = '0; a_mwdata = '0; a_sack = '0; a_srdata = '0;
    b_mreq = '0; b_mcmd = '0; b_maddr = '0; b_mwdata = '0; b_sack = '0; b_srdata = '0;
    reset = 1'b1;
    cyc();
    cyc();
    #1;
    checks++;
    if (a_sreq !== 2'b00 || a_mack !== 2'b00 || a_merr !== 2'b00 || a_mrdata !== '0) begin
      errors++;
      $display("FAIL reset_a got sreq=%b mack=%b merr=%b exp all 0", a_sreq, a_mack, a_merr);
    end
    checks++;
    if (b_sreq !== 4'b0000 || b_mack !== 4'b0000 || b_saddr !== '0) begin
      errors++;
      $display("FAIL reset_b got sreq=%b mack=%b exp 0", b_sreq, b_mack);
    end
    reset = 1'b0;
  endtask

  // Both masters hold requests to slave 0 continuously; grants must alternate.
  task automatic test_round_robin();
    logic [SAW-1:0] ea;
    logic [DW-1:0]  ew;
    logic [NM-1:0]  eack;
    int g;
    cyc();
    a_mreq = 2'b11; a_mcmd = 2'b11;
    a_maddr = {32'h0000000B, 32'h0000000A};
    a_mwdata = {32'h0000000B, 32'h0000000A};
    #1;
    checks++;
    if (a_sreq !== 2'b00) begin
      errors++;
      $display("FAIL rr_latency got sreq=%b exp 00", a_sreq);
    end
    for (int i = 0; i < 8; i++) begin
      g = i % 2;
      ea = (g == 0) ? SAW'(32'h0000000A) : SAW'(32'h0000000B);
      ew = (g == 0) ? 32'h0000000A : 32'h0000000B;
      eack = (g == 0) ? 2'b01 : 2'b10;
      cyc();
      checks++;
      if (a_sreq !== 2'b01 || a_scmd[0] !== 1'b1 || a_saddr[0 +: SAW] !== ea || a_swdata[0 +: DW] !== ew) begin
        errors++;
        $display("FAIL rr_grant%0d got sreq=%b addr=%h wdata=%h exp sreq=01 addr=%h wdata=%h",
                 i, a_sreq, a_saddr[0 +: SAW], a_swdata[0 +: DW], ea, ew);
      end
      a_sack = 2'b01;
      #1;
      checks++;
      if (a_mack !== eack || a_merr !== 2'b00) begin
        errors++;
        $display("FAIL rr_ack%0d got mack=%b merr=%b exp mack=%b merr=00", i, a_mack, a_merr, eack);
      end
      cyc();
      a_sack = 2'b00;
      #1;
      checks++;
      if (a_sreq !== 2'b00 || a_mack !== 2'b00) begin
        errors++;
        $display("FAIL rr_gap%0d got sreq=%b mack=%b exp 00 00", i, a_sreq, a_mack);
      end
    end
    a_mreq = 2'b00;
    cyc();
  endtask

  task automatic test_concurrent();
    a_mreq = 2'b11; a_mcmd = 2'b00;
    a_maddr = {32'h8000000B, 32'h0000000A};
    a_mwdata = '0;
    cyc();
    checks++;
    if (a_sreq !== 2'b11 || a_scmd !== 2'b00 || a_saddr[SAW +: SAW] !== SAW'(32'h0000000B) ||
        a_saddr[0 +: SAW] !== SAW'(32'h0000000A)) begin
      errors++;
      $display("FAIL conc_req got sreq=%b cmd=%b addr1=%h addr0=%h exp 11 00 0000000b 0000000a",
               a_sreq, a_scmd, a_saddr[SAW +: SAW], a_saddr[0 +: SAW]);
    end
    a_sack = 2'b11;
    a_srdata = {32'h000000BB, 32'h000000AA};
    #1;
    checks++;
    if (a_mack !== 2'b11 || a_mrdata !== {32'h000000BB, 32'h000000AA} || a_merr !== 2'b00) begin
      errors++;
      $display("FAIL conc_ack got mack=%b rdata=%h merr=%b exp 11 000000bb000000aa 00",
               a_mack, a_mrdata, a_merr);
    end
    cyc();
    a_mreq = 2'b00;
    a_sack = 2'b00;
    #1;
    checks++;
    if (a_sreq !== 2'b00 || a_mrdata !== '0) begin
      errors++;
      $display("FAIL conc_gap got sreq=%b rdata=%h exp 00 0", a_sreq, a_mrdata);
    end
    cyc();
    a_sack = 2'b11;
    #1;
    checks++;
    if (a_mack !== 2'b00 || a_mrdata !== '0 || a_sreq !== 2'b00) begin
      errors++;
      $display("FAIL idle_ack got mack=%b rdata=%h sreq=%b exp 00 0 00", a_mack, a_mrdata, a_sreq);
    end
    a_sack = 2'b00;
    a_srdata = '0;
  endtask

  task automatic test_4x4();
    for (int m = 0; m < BM; m++) begin
      b_maddr[m*AW +: AW] = 32'h80000000 | 32'(m);
      b_mwdata[m*DW +: DW] = 32'h100 + 32'(m);
    end
    b_mcmd = 4'b1111;
    b_mreq = 4'b1111;
    for (int m = 0; m < BM; m++) begin
      cyc();
      checks++;
      if (b_sreq !== 4'b0100 || b_saddr[2*BSAW +: BSAW] !== BSAW'(m) ||
          b_swdata[2*DW +: DW] !== 32'h100 + 32'(m)) begin
        errors++;
        $display("FAIL b_grant%0d got sreq=%b addr=%h wdata=%h exp 0100 %h %h",
                 m, b_sreq, b_saddr[2*BSAW +: BSAW], b_swdata[2*DW +: DW], m, 32'h100 + 32'(m));
      end
      b_sack = 4'b0100;
      #1;
      checks++;
      if (b_mack !== 4'(1 << m)) begin
        errors++;
        $display("FAIL b_ack%0d got mack=%b exp %b", m, b_mack, 4'(1 << m));
      end
      cyc();
      b_sack = 4'b0000;
      b_mreq[m] = 1'b0;
      #1;
      checks++;
      if (b_sreq !== 4'b0000) begin
        errors++;
        $display("FAIL b_gap%0d got sreq=%b exp 0000", m, b_sreq);
      end
    end
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    a_mreq = 2'b01; a_mcmd = 2'b00;
    a_maddr = {32'h0, 32'h80000000};
`ifdef CROSSBAR_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      cyc();
      if (a_sreq !== 2'b10 || a_mack !== 2'b00) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL to_wait got %0d bad cycles exp 0", bad);
    end
    cyc();
    checks++;
    if (a_sreq !== 2'b00 || a_mack !== 2'b01 || a_merr !== 2'b01 || a_mrdata !== '0) begin
      errors++;
      $display("FAIL to_fire got sreq=%b mack=%b merr=%b rdata=%h exp 00 01 01 0",
               a_sreq, a_mack, a_merr, a_mrdata);
    end
    a_mreq = 2'b00;
    cyc();
    checks++;
    if (a_mack !== 2'b00 || a_merr !== 2'b00) begin
      errors++;
      $display("FAIL to_after got mack=%b merr=%b exp 00 00", a_mack, a_merr);
    end
`else
    for (int k = 1; k <= 100; k++) begin
      cyc();
      if (a_sreq !== 2'b10 || a_mack !== 2'b00 || a_merr !== 2'b00) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL no_to_wait got %0d bad cycles exp 0", bad);
    end
    a_sack = 2'b10;
    a_srdata = {32'h000000CC, 32'h0};
    #1;
    checks++;
    if (a_mack !== 2'b01 || a_mrdata[0 +: DW] !== 32'h000000CC) begin
      errors++;
      $display("FAIL no_to_ack got mack=%b rdata=%h exp 01 000000cc", a_mack, a_mrdata[0 +: DW]);
    end
    cyc();
    a_sack = 2'b00;
    a_srdata = '0;
    a_mreq = 2'b00;
`endif
    cyc();
  endtask

  // Slave 0 rr_ptr is 1 here, so master 1 wins before the reset.
  task automatic test_reset_mid();
    a_mreq = 2'b10; a_mcmd = 2'b11;
    a_maddr = {32'h0000000B, 32'h0000000A};
    a_mwdata = {32'h0000000B, 32'h0000000A};
    cyc();
    checks++;
    if (a_sreq !== 2'b01 || a_saddr[0 +: SAW] !== SAW'(32'h0000000B)) begin
      errors++;
      $display("FAIL rm_pre got sreq=%b addr=%h exp 01 0000000b", a_sreq, a_saddr[0 +: SAW]);
    end
    reset = 1'b1;
    cyc();
    checks++;
    if (a_sreq !== 2'b00 || a_mack !== 2'b00) begin
      errors++;
      $display("FAIL rm_abandon got sreq=%b mack=%b exp 00 00", a_sreq, a_mack);
    end
    reset = 1'b0;
    a_mreq = 2'b11;
    cyc();
    checks++;
    if (a_sreq !== 2'b01 || a_saddr[0 +: SAW] !== SAW'(32'h0000000A)) begin
      errors++;
      $display("FAIL rm_regrant got sreq=%b addr=%h exp 01 0000000a", a_sreq, a_saddr[0 +: SAW]);
    end
    a_sack = 2'b01;
    #1;
    checks++;
    if (a_mack !== 2'b01) begin
      errors++;
      $display("FAIL rm_ack got mack=%b exp 01", a_mack);
    end
    cyc();
    a_sack = 2'b00;
    a_mreq = 2'b00;
    cyc();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_concurrent();
    test_4x4();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
